// File: rtl/pipe_pkg.sv
// Shared pipeline payload types and widths.
// Each stage boundary gets its own packed bundle.
package pipe_pkg;

  typedef enum logic {
    PASS = 1'b0,
    FULL = 1'b1
  } skid_st_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } memwb_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exmem_t;

  localparam int MEMWB_W = $bits(memwb_t);
  localparam int EXMEM_W = $bits(exmem_t);

endpackage

// File: rtl/pipe_stage_hs_skid.sv
// One-entry skid buffer with PASS/FULL state.
// Holds the beat accepted while the output register is stalled.
import pipe_pkg::*;

module pipe_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] in_data,
  output logic             full,
  output logic [WIDTH-1:0] skid_data
);

  skid_st_e state;
  skid_st_e state_nxt;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= PASS;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      PASS: if (load) state_nxt = FULL;
      FULL: if (unload) state_nxt = PASS;
      default: state_nxt = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      skid_data <= '0;
    end else if (load && state == PASS) begin
      skid_data <= in_data;
    end
  end

  assign full = (state == FULL);

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with optional skid,
// synchronous flush and a saturating stall counter.
import pipe_pkg::*;

module pipe_stage_hs #(
  parameter int WIDTH = MEMWB_W,
  parameter int SKID  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             in_xfer;
  logic             out_xfer;
  logic             stalled;
  logic             to_skid;
  logic             from_skid;
  logic             skid_full;
  logic [WIDTH-1:0] skid_data;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign stalled   = out_valid && !out_ready;
  assign from_skid = skid_full && out_xfer;

  if (SKID != 0) begin : g_skid
    assign to_skid  = in_xfer && stalled;
    assign in_ready = !skid_full;

    pipe_skid_buf #(
      .WIDTH(WIDTH)
    ) u_skid (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .load     (to_skid),
      .unload   (out_xfer),
      .in_data  (in_data),
      .full     (skid_full),
      .skid_data(skid_data)
    );
  end else begin : g_noskid
    assign to_skid   = 1'b0;
    assign skid_full = 1'b0;
    assign skid_data = '0;
    // Flush retires the presented beat upstream even when stalled
    assign in_ready  = out_ready || !out_valid || flush;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (from_skid) begin
      out_data  <= skid_data;
    end else if (in_xfer && !to_skid) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stall_clr) begin
      stall_cnt <= '0;
    end else if (stalled && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs in both skid modes
// plus a narrow-counter instance for saturation.
module tb_pipe_stage_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        flush;
  logic        out_ready;
  logic        stall_clr;

  logic        r0, v0, r1, v1, r2, v2;
  logic [31:0] d0, d1, d2;
  logic [15:0] c0, c1;
  logic [2:0]  c2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.WIDTH(32), .SKID(0), .CNT_W(16)) u_d0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r0),
    .in_data(in_data), .flush(flush), .out_valid(v0),
    .out_ready(out_ready), .out_data(d0), .stall_cnt(c0),
    .stall_clr(stall_clr)
  );

  pipe_stage_hs #(.WIDTH(32), .SKID(1), .CNT_W(16)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r1),
    .in_data(in_data), .flush(flush), .out_valid(v1),
    .out_ready(out_ready), .out_data(d1), .stall_cnt(c1),
    .stall_clr(stall_clr)
  );

  pipe_stage_hs #(.WIDTH(32), .SKID(0), .CNT_W(3)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r2),
    .in_data(in_data), .flush(flush), .out_valid(v2),
    .out_ready(out_ready), .out_data(d2), .stall_cnt(c2),
    .stall_clr(stall_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    stall_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hdead;
    flush = 1'b0;
    out_ready = 1'b0;
    stall_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (v0 !== 1'b0 || v1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b/%b expected 0/0", v0, v1);
    end
    tests++;
    if (d0 !== 32'h0 || d1 !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h expected 0/0", d0, d1);
    end
    tests++;
    if (r1 !== 1'b1 || r0 !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b/%b expected 1/1", r0, r1);
    end
    tests++;
    if (c0 !== 16'd0 || c1 !== 16'd0) begin
      fails++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", c0, c1);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = i;
      tick();
      tests++;
      if (v0 !== 1'b1 || d0 !== i) begin
        fails++;
        $display("FAIL stream_s0[%0d]: got v=%b d=%h expected v=1 d=%h",
                 i, v0, d0, i);
      end
      tests++;
      if (v1 !== 1'b1 || d1 !== i || r1 !== 1'b1) begin
        fails++;
        $display("FAIL stream_s1[%0d]: got v=%b d=%h r=%b expected 1 %h 1",
                 i, v1, d1, r1, i);
      end
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (v0 !== 1'b0 || v1 !== 1'b0) begin
      fails++;
      $display("FAIL stream_drain: got %b/%b expected 0/0", v0, v1);
    end
  endtask

  task automatic test_bp_skid1();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'hA;
    exp_seq[1] = 32'hB;
    exp_seq[2] = 32'hC;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    tests++;
    if (d1 !== 32'hA || v1 !== 1'b1 || r1 !== 1'b0) begin
      fails++;
      $display("FAIL bp1_fill: got d=%h v=%b r=%b expected a 1 0",
               d1, v1, r1);
    end
    in_data = 32'hC;
    tick();
    tests++;
    if (d1 !== 32'hA || r1 !== 1'b0) begin
      fails++;
      $display("FAIL bp1_hold: got d=%h r=%b expected a 0", d1, r1);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      tests++;
      if (d1 !== exp_seq[i] || v1 !== 1'b1) begin
        fails++;
        $display("FAIL bp1_drain[%0d]: got d=%h v=%b expected %h 1",
                 i, d1, v1, exp_seq[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (v1 !== 1'b0) begin
      fails++;
      $display("FAIL bp1_empty: got v=%b expected 0", v1);
    end
    tests++;
    if (c1 !== 16'd2) begin
      fails++;
      $display("FAIL bp1_cnt: got %0d expected 2", c1);
    end
  endtask

  task automatic test_bp_skid0();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h77;
    tick();
    out_ready = 1'b0;
    in_data = 32'h78;
    #1;
    tests++;
    if (r0 !== 1'b0) begin
      fails++;
      $display("FAIL bp0_ready: got %b expected 0", r0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (d0 !== 32'h77 || v0 !== 1'b1) begin
        fails++;
        $display("FAIL bp0_stable[%0d]: got d=%h v=%b expected 77 1",
                 i, d0, v0);
      end
    end
    tests++;
    if (c0 !== 16'd5) begin
      fails++;
      $display("FAIL bp0_cnt: got %0d expected 5", c0);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (r0 !== 1'b1) begin
      fails++;
      $display("FAIL bp0_release: got %b expected 1", r0);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (d0 !== 32'h78) begin
      fails++;
      $display("FAIL bp0_next: got %h expected 78", d0);
    end
  endtask

  task automatic test_flush_full();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    tests++;
    if (r1 !== 1'b0) begin
      fails++;
      $display("FAIL flush_pre_full: got r=%b expected 0", r1);
    end
    flush = 1'b1;
    in_data = 32'h33;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (v1 !== 1'b0 || d1 !== 32'h0 || r1 !== 1'b1) begin
      fails++;
      $display("FAIL flush_state: got v=%b d=%h r=%b expected 0 0 1",
               v1, d1, r1);
    end
    out_ready = 1'b1;
    tick();
    tick();
    tests++;
    if (v1 !== 1'b0 || d1 !== 32'h0) begin
      fails++;
      $display("FAIL flush_no_leak: got v=%b d=%h expected 0 0", v1, d1);
    end
  endtask

  task automatic test_cnt_sat();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h5;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (c2 !== 3'd7) begin
      fails++;
      $display("FAIL cnt_sat: got %0d expected 7", c2);
    end
    stall_clr = 1'b1;
    tick();
    tests++;
    if (c2 !== 3'd0) begin
      fails++;
      $display("FAIL cnt_clr: got %0d expected 0", c2);
    end
    stall_clr = 1'b0;
    tick();
    tests++;
    if (c2 !== 3'd1) begin
      fails++;
      $display("FAIL cnt_resume: got %0d expected 1", c2);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tests++;
    if (c2 !== 3'd2 || v2 !== 1'b0) begin
      fails++;
      $display("FAIL cnt_flush: got c=%0d v=%b expected 2 0", c2, v2);
    end
  endtask

  task automatic test_simul();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h44;
    tick();
    in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    tests++;
    if (d0 !== 32'h55 || v0 !== 1'b1) begin
      fails++;
      $display("FAIL simul_s0: got d=%h v=%b expected 55 1", d0, v0);
    end
    tests++;
    if (d1 !== 32'h55 || v1 !== 1'b1) begin
      fails++;
      $display("FAIL simul_s1: got d=%h v=%b expected 55 1", d1, v1);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h66;
    tick();
    in_data = 32'h67;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (v1 !== 1'b0 || r1 !== 1'b1 || c1 !== 16'd0) begin
      fails++;
      $display("FAIL reset_stall: got v=%b r=%b c=%0d expected 0 1 0",
               v1, r1, c1);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_bp_skid1();
    test_bp_skid0();
    test_flush_full();
    test_cnt_sat();
    test_simul();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
